// File: rtl/v810_bus_ctlr.sv
// V810 external bus cycle controller: decodes each cycle into a region, drives the
// chip enables and read select, counts wait states or timeout, and returns READYn/SZRQn.
module v810_bus_ctlr #(
    parameter int TIMEOUT = 15,
    parameter int CW      = 8
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic [31:0] A,
    input  logic        MRQn,
    input  logic        RW,
    input  logic [3:0]  BEn,
    input  logic        BCYSTn,
    input  logic        DAn,
    input  logic [3:0]  RAM_WS,
    input  logic [3:0]  ROM_WS,
    input  logic [3:0]  IO_WS,
    output logic        READYn,
    output logic        SZRQn,
    output logic        RAM_CEn,
    output logic        ROM_CEn,
    output logic        IO_CEn,
    output logic [3:0]  MEM_BEn,
    output logic [1:0]  DSEL,
    output logic        BERR,
    output logic        BUSY
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    // Region codes double as the DSEL read-mux encoding (unmapped reads return zero).
    typedef enum logic [1:0] {
        RGN_NONE = 2'd0,
        RGN_RAM  = 2'd1,
        RGN_ROM  = 2'd2,
        RGN_IO   = 2'd3
    } region_t;

    state_t        state, state_d;
    region_t       region, region_d, start_region;
    logic [CW-1:0] cnt, cnt_d, start_ws;
    logic          ready_n_d, szrq_n_d, berr_d, busy_d;
    logic          ram_ce_n_d, rom_ce_n_d, io_ce_n_d;
    logic [3:0]    mem_ben_d;
    logic [1:0]    dsel_d;

    logic [19:0]   unused_addr;
    assign unused_addr = A[19:0];

    always_comb begin
        if (MRQn)                    start_region = RGN_IO;
        else if (!A[31])             start_region = RGN_RAM;
        else if (A[31:20] == 12'hFFF) start_region = RGN_ROM;
        else                         start_region = RGN_NONE;
    end

    always_comb begin
        case (start_region)
            RGN_RAM: start_ws = CW'(RAM_WS);
            RGN_ROM: start_ws = CW'(ROM_WS);
            RGN_IO:  start_ws = CW'(IO_WS);
            default: start_ws = CW'(TIMEOUT);
        endcase
    end

    always_comb begin
        // NOTE: every signal is given its hold value first so no path through this
        // block leaves one unassigned, which would otherwise infer a latch.
        state_d    = state;
        region_d   = region;
        cnt_d      = cnt;
        ready_n_d  = READYn;
        szrq_n_d   = SZRQn;
        berr_d     = BERR;
        busy_d     = BUSY;
        ram_ce_n_d = RAM_CEn;
        rom_ce_n_d = ROM_CEn;
        io_ce_n_d  = IO_CEn;
        mem_ben_d  = MEM_BEn;
        dsel_d     = DSEL;

        if (CE) begin
            case (state)
                ST_IDLE: begin
                    if (!BCYSTn) begin
                        state_d    = ST_WAIT;
                        region_d   = start_region;
                        cnt_d      = start_ws;
                        busy_d     = 1'b1;
                        mem_ben_d  = BEn;
                        ram_ce_n_d = (start_region != RGN_RAM);
                        rom_ce_n_d = (start_region != RGN_ROM);
                        io_ce_n_d  = (start_region != RGN_IO);
                        dsel_d     = RW ? start_region : RGN_NONE;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state_d   = ST_ACK;
                        ready_n_d = 1'b0;
                        szrq_n_d  = !(region == RGN_ROM || region == RGN_IO);
                        berr_d    = (region == RGN_NONE);
                    end else if (!DAn) begin
                        cnt_d = cnt - CW'(1);
                    end
                end
                ST_ACK: begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    ready_n_d  = 1'b1;
                    szrq_n_d   = 1'b1;
                    berr_d     = 1'b0;
                    ram_ce_n_d = 1'b1;
                    rom_ce_n_d = 1'b1;
                    io_ce_n_d  = 1'b1;
                    dsel_d     = RGN_NONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state   <= ST_IDLE;
            region  <= RGN_NONE;
            cnt     <= '0;
            READYn  <= 1'b1;
            SZRQn   <= 1'b1;
            BERR    <= 1'b0;
            BUSY    <= 1'b0;
            RAM_CEn <= 1'b1;
            ROM_CEn <= 1'b1;
            IO_CEn  <= 1'b1;
            MEM_BEn <= 4'hF;
            DSEL    <= 2'd0;
        end else begin
            state   <= state_d;
            region  <= region_d;
            cnt     <= cnt_d;
            READYn  <= ready_n_d;
            SZRQn   <= szrq_n_d;
            BERR    <= berr_d;
            BUSY    <= busy_d;
            RAM_CEn <= ram_ce_n_d;
            ROM_CEn <= rom_ce_n_d;
            IO_CEn  <= io_ce_n_d;
            MEM_BEn <= mem_ben_d;
            DSEL    <= dsel_d;
        end
    end

endmodule

// File: tb/tb_v810_bus_ctlr.sv
// Bench for v810_bus_ctlr: fixed vector table, hand-written corner sequences and
// randomized cycles checked against a transaction-level model of the bus rules.
module tb_v810_bus_ctlr;

    localparam int TIMEOUT = 15;

    logic        CLK, RES, CE;
    logic [31:0] A;
    logic        MRQn, RW, BCYSTn, DAn;
    logic [3:0]  BEn, RAM_WS, ROM_WS, IO_WS;
    logic        READYn, SZRQn, RAM_CEn, ROM_CEn, IO_CEn, BERR, BUSY;
    logic [3:0]  MEM_BEn;
    logic [1:0]  DSEL;

    v810_bus_ctlr #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
        .CLK(CLK), .RES(RES), .CE(CE), .A(A), .MRQn(MRQn), .RW(RW), .BEn(BEn),
        .BCYSTn(BCYSTn), .DAn(DAn), .RAM_WS(RAM_WS), .ROM_WS(ROM_WS), .IO_WS(IO_WS),
        .READYn(READYn), .SZRQn(SZRQn), .RAM_CEn(RAM_CEn), .ROM_CEn(ROM_CEn),
        .IO_CEn(IO_CEn), .MEM_BEn(MEM_BEn), .DSEL(DSEL), .BERR(BERR), .BUSY(BUSY)
    );

    typedef struct {
        logic [31:0] a;
        logic        mrqn;
        logic        rw;
        logic [3:0]  ben;
        logic [3:0]  ram_ws;
        logic [3:0]  rom_ws;
        logic [3:0]  io_ws;
        logic [2:0]  cen;   // {RAM,ROM,IO} active low
        logic [1:0]  dsel;
        logic        szrq;
        logic        berr;
        int          ack;   // CE ticks from start to ACK entry
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int clk_count = 0;
    int last_ce_clk, start_clk, ack_clk;
    bit ce_toggle = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) clk_count <= clk_count + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sample();
        return {19'd0, MEM_BEn, READYn, SZRQn, RAM_CEn, ROM_CEn, IO_CEn, DSEL, BERR, BUSY};
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] ben, input logic rdy, input logic sz,
                                       input logic [2:0] cen, input logic [1:0] dsel,
                                       input logic berr, input logic busy);
        return {19'd0, ben, rdy, sz, cen, dsel, berr, busy};
    endfunction

    // Region as the bus map defines it, with plain address-range comparisons.
    function automatic logic [1:0] model_region(input logic [31:0] a, input logic mrqn);
        if (mrqn)                return 2'd3;
        if (a < 32'h8000_0000)   return 2'd1;
        if (a >= 32'hFFF0_0000)  return 2'd2;
        return 2'd0;
    endfunction

    // ACK comes one tick after the ws-th tick that had DAn low.
    function automatic int model_ack(input int ws, input logic [63:0] pat);
        int lows = 0;
        for (int j = 1; j < 200; j++) begin
            if (lows == ws) return j;
            if (j > 64) lows++;
            else if (!pat[j-1]) lows++;
        end
        return 200;
    endfunction

    function automatic vec_t model_vec(input logic [31:0] a, input logic mrqn, input logic rw,
                                       input logic [3:0] ben, input logic [3:0] rws,
                                       input logic [3:0] ows, input logic [3:0] iws,
                                       input logic [63:0] pat);
        vec_t v;
        logic [1:0] r;
        int ws;
        r = model_region(a, mrqn);
        v.a = a; v.mrqn = mrqn; v.rw = rw; v.ben = ben;
        v.ram_ws = rws; v.rom_ws = ows; v.io_ws = iws;
        case (r)
            2'd1:    begin v.cen = 3'b011; ws = int'(rws); end
            2'd2:    begin v.cen = 3'b101; ws = int'(ows); end
            2'd3:    begin v.cen = 3'b110; ws = int'(iws); end
            default: begin v.cen = 3'b111; ws = TIMEOUT;   end
        endcase
        v.dsel = rw ? r : 2'd0;
        v.szrq = !(r == 2'd2 || r == 2'd3);
        v.berr = (r == 2'd0);
        v.ack  = model_ack(ws, pat);
        return v;
    endfunction

    // Advance to the next clock edge that has CE=1, then return at the falling edge.
    task automatic ce_step();
        logic hit;
        hit = 1'b0;
        while (!hit) begin
            hit = CE;
            @(posedge CLK);
            #1;
            if (hit) last_ce_clk = clk_count;
            if (ce_toggle) CE = ~CE;
        end
        @(negedge CLK);
    endtask

    task automatic run_cycle(input vec_t v, input logic [63:0] pat, input bit hold,
                             input string tag);
        logic [31:0] exp;
        A = v.a; MRQn = v.mrqn; RW = v.rw; BEn = v.ben;
        RAM_WS = v.ram_ws; ROM_WS = v.rom_ws; IO_WS = v.io_ws;
        BCYSTn = 1'b0; DAn = 1'b1;
        ce_step();
        start_clk = last_ce_clk;
        check($sformatf("%s start", tag), sample(), mk(v.ben, 1, 1, v.cen, v.dsel, 0, 1));
        if (!hold) BCYSTn = 1'b1;
        // Everything but DAn is latched at start; disturb it all mid-cycle.
        A = $urandom; MRQn = ~v.mrqn; RW = ~v.rw; BEn = ~v.ben;
        RAM_WS = v.ram_ws ^ 4'($urandom_range(1, 15));
        ROM_WS = v.rom_ws ^ 4'($urandom_range(1, 15));
        IO_WS  = v.io_ws  ^ 4'($urandom_range(1, 15));
        for (int j = 1; j <= v.ack + 1; j++) begin
            DAn = (j <= 64) ? pat[j-1] : 1'b0;
            ce_step();
            if (j < v.ack)
                exp = mk(v.ben, 1, 1, v.cen, v.dsel, 0, 1);
            else if (j == v.ack) begin
                exp = mk(v.ben, 0, v.szrq, v.cen, v.dsel, v.berr, 1);
                ack_clk = last_ce_clk;
            end else
                exp = mk(v.ben, 1, 1, 3'b111, 2'd0, 0, 0);
            check($sformatf("%s t%0d", tag, j), sample(), exp);
        end
        BCYSTn = 1'b1; DAn = 1'b1;
    endtask

    vec_t tbl [10];
    vec_t v;
    logic [63:0] pat;
    int d_norm, d_stall;

    initial begin
        tbl[0] = '{32'h0000_0010, 1'b0, 1'b1, 4'h0, 4'd0,  4'd3,  4'd2, 3'b011, 2'd1, 1'b1, 1'b0, 1};
        tbl[1] = '{32'hFFF0_0004, 1'b0, 1'b1, 4'hC, 4'd0,  4'd3,  4'd2, 3'b101, 2'd2, 1'b0, 1'b0, 4};
        tbl[2] = '{32'h9000_0000, 1'b0, 1'b1, 4'h3, 4'd0,  4'd3,  4'd2, 3'b111, 2'd0, 1'b1, 1'b1, 16};
        tbl[3] = '{32'h0000_0100, 1'b1, 1'b0, 4'h5, 4'd0,  4'd3,  4'd2, 3'b110, 2'd0, 1'b0, 1'b0, 3};
        tbl[4] = '{32'h7FFF_FFFC, 1'b0, 1'b0, 4'hA, 4'd2,  4'd0,  4'd0, 3'b011, 2'd0, 1'b1, 1'b0, 3};
        tbl[5] = '{32'h8000_0000, 1'b0, 1'b1, 4'h0, 4'd0,  4'd0,  4'd0, 3'b111, 2'd0, 1'b1, 1'b1, 16};
        tbl[6] = '{32'hFFEF_FFFF, 1'b0, 1'b0, 4'hF, 4'd0,  4'd0,  4'd0, 3'b111, 2'd0, 1'b1, 1'b1, 16};
        tbl[7] = '{32'hFFF0_0000, 1'b0, 1'b0, 4'h1, 4'd0,  4'd15, 4'd0, 3'b101, 2'd0, 1'b0, 1'b0, 16};
        tbl[8] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 4'h2, 4'd9,  4'd9,  4'd0, 3'b110, 2'd3, 1'b0, 1'b0, 1};
        tbl[9] = '{32'h0000_0000, 1'b0, 1'b1, 4'h8, 4'd15, 4'd0,  4'd0, 3'b011, 2'd1, 1'b1, 1'b0, 16};

        RES = 1'b1; CE = 1'b1; A = '0; MRQn = 1'b0; RW = 1'b1; BEn = 4'h0;
        BCYSTn = 1'b0; DAn = 1'b0; RAM_WS = '0; ROM_WS = '0; IO_WS = '0;
        repeat (3) @(negedge CLK);
        check("reset values", sample(), mk(4'hF, 1, 1, 3'b111, 2'd0, 0, 0));
        BCYSTn = 1'b1; DAn = 1'b1;
        RES = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 10; i++)
            run_cycle(tbl[i], 64'd0, bit'(i % 2), $sformatf("vec%0d", i));

        // I/O write with CE at half rate: 3 CE ticks are 6 clocks.
        ce_toggle = 1;
        run_cycle(tbl[3], 64'd0, 1'b0, "io_ce_half");
        check("io_ce_half clocks", 32'(ack_clk - start_clk), 32'd6);
        ce_toggle = 0; CE = 1'b1;
        @(negedge CLK);

        // DAn high for the first 4 wait ticks stretches a WS=5 RAM cycle by 4 ticks.
        v = model_vec(32'h0000_4000, 1'b0, 1'b1, 4'h6, 4'd5, 4'd0, 4'd0, 64'd0);
        check("ram ws5 model ack", 32'(v.ack), 32'd6);
        run_cycle(v, 64'd0, 1'b0, "ram_ws5");
        d_norm = ack_clk - start_clk;
        v.ack = 10;
        run_cycle(v, 64'hF, 1'b0, "ram_ws5_stall");
        d_stall = ack_clk - start_clk;
        check("dan stall delta", 32'(d_stall - d_norm), 32'd4);

        // Asynchronous reset in the middle of a ROM wait.
        A = 32'hFFF0_1234; MRQn = 1'b0; RW = 1'b1; BEn = 4'h3; ROM_WS = 4'd5;
        BCYSTn = 1'b0;
        ce_step();
        check("rom pre-reset", sample(), mk(4'h3, 1, 1, 3'b101, 2'd2, 0, 1));
        BCYSTn = 1'b1; DAn = 1'b0;
        ce_step();
        ce_step();
        #2;
        RES = 1'b1;
        #1;
        check("async reset mid-wait", sample(), mk(4'hF, 1, 1, 3'b111, 2'd0, 0, 0));
        @(negedge CLK);
        check("reset held", sample(), mk(4'hF, 1, 1, 3'b111, 2'd0, 0, 0));
        RES = 1'b0;
        @(negedge CLK);
        v = model_vec(32'hFFF8_0000, 1'b0, 1'b1, 4'h9, 4'd0, 4'd2, 4'd0, 64'd0);
        run_cycle(v, 64'd0, 1'b0, "post_reset_rom");
        check("post_reset_rom clocks", 32'(ack_clk - start_clk), 32'd3);

        // Randomized cycles against the model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic        rm;
            case ($urandom_range(0, 4))
                0: begin ra = $urandom & 32'h7FFF_FFFF;                 rm = 1'b0; end
                1: begin ra = 32'hFFF0_0000 | ($urandom & 32'h000F_FFFF); rm = 1'b0; end
                2: begin ra = 32'h8000_0000 + $urandom_range(0, 32'h7FEF_FFFF); rm = 1'b0; end
                3: begin ra = $urandom;                                 rm = 1'b1; end
                default: begin ra = $urandom;                           rm = 1'($urandom_range(0, 1)); end
            endcase
            pat = ($urandom_range(0, 3) == 0) ? 64'd0
                : {$urandom & $urandom, $urandom & $urandom};
            v = model_vec(ra, rm, 1'($urandom_range(0, 1)), 4'($urandom),
                          4'($urandom), 4'($urandom), 4'($urandom), pat);
            ce_toggle = ($urandom_range(0, 3) == 0);
            CE = 1'b1;
            run_cycle(v, pat, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            ce_toggle = 0; CE = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
